inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_inst_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Byte-serial instruction fetch: assembles four little-endian bytes from a
// registered-read memory into a 32-bit instruction, with stall and redirect.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] MEM_BYTES = 32'd32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] redirect_pc;
  logic [31:0] branch_pc;
  logic        do_redirect;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      cnt_q      <= 3'd0;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign branch_pc = branch_target & 32'hFFFF_FFFC;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    redirect_pc = pc_q;
    do_redirect = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = RESET_PC;
          cnt_d   = 3'd0;
        end
      end
      FETCH: begin
        if (branch_valid) begin
          do_redirect = 1'b1;
          redirect_pc = branch_pc;
        end else begin
          // Memory read is registered, so the byte arriving at cnt=k was
          // addressed at cnt=k-1.
          case (cnt_q)
            3'd1:    instr_d[7:0]   = mem_data;
            3'd2:    instr_d[15:8]  = mem_data;
            3'd3:    instr_d[23:16] = mem_data;
            3'd4:    instr_d[31:24] = mem_data;
            default: ;
          endcase
          if (cnt_q == 3'd4) begin
            state_d    = HOLD;
            cnt_d      = 3'd0;
            instr_pc_d = pc_q;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      HOLD: begin
        if (instr_ready) begin
          do_redirect = 1'b1;
          redirect_pc = branch_valid ? branch_pc : pc_q + 32'd4;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_redirect) begin
      pc_d    = redirect_pc;
      cnt_d   = 3'd0;
      state_d = (redirect_pc >= MEM_BYTES) ? DONE : FETCH;
    end
  end

  always_comb begin
    mem_addr = pc_q;
    if (state_q == FETCH) begin
      mem_addr = (cnt_q == 3'd4) ? pc_q + 32'd3 : pc_q + {29'd0, cnt_q};
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = (state_q == HOLD);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: a byte memory plus a transaction-level model
// predicting addresses, assembled words, pc progression and termination.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] MEM_BYTES = 32'd32;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        done;

  inst_fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .MEM_BYTES (MEM_BYTES)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .done          (done)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:31];

  always @(posedge clock)
    mem_data <= (mem_addr < MEM_BYTES) ? mem[mem_addr[4:0]] : 8'h00;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic [31:0] cur_pc;
  bit          stopped;
  bit          in_hold;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {mem[pc[4:0] + 5'd3], mem[pc[4:0] + 5'd2], mem[pc[4:0] + 5'd1], mem[pc[4:0]]};
  endfunction

  // Called right after the clock edge that changed the fetch pc.
  task automatic redirect(input logic [31:0] nxt);
    cur_pc  = nxt;
    stopped = (nxt >= MEM_BYTES);
    in_hold = 1'b0;
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_done", {31'd0, done}, {31'd0, stopped});
    if (stopped) chk("done_addr", mem_addr, nxt);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start   = 1'b0;
    cur_pc  = RESET_PC;
    stopped = 1'b0;
    in_hold = 1'b0;
    chk("start_done", {31'd0, done}, 32'd0);
  endtask

  // Entered in FETCH with cnt=0; br_at selects a byte slot for a redirect.
  task automatic do_fetch(input int br_at, input logic [31:0] tgt);
    for (int k = 0; k <= 4; k++) begin
      chk("fetch_addr", mem_addr, cur_pc + 32'((k > 3) ? 3 : k));
      chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
      start = ($urandom_range(0, 3) == 0);
      if (k == br_at) begin
        branch_valid  = 1'b1;
        branch_target = tgt;
        tick();
        branch_valid = 1'b0;
        start        = 1'b0;
        redirect(tgt & 32'hFFFF_FFFC);
        return;
      end
      tick();
    end
    start   = 1'b0;
    in_hold = 1'b1;
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_instr", instr, word_at(cur_pc));
    chk("hold_pc", instr_pc, cur_pc);
    chk("hold_addr", mem_addr, cur_pc);
  endtask

  task automatic do_hold(input int stall, input bit br, input logic [31:0] tgt);
    logic [31:0] exp_word;
    exp_word = word_at(cur_pc);
    for (int s = 0; s < stall; s++) begin
      instr_ready   = 1'b0;
      branch_valid  = $urandom_range(0, 1) == 1;
      branch_target = $urandom_range(0, 39);
      start         = $urandom_range(0, 1) == 1;
      tick();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, exp_word);
      chk("stall_pc", instr_pc, cur_pc);
    end
    start         = 1'b0;
    instr_ready   = 1'b1;
    branch_valid  = br;
    branch_target = tgt;
    tick();
    instr_ready  = 1'b0;
    branch_valid = 1'b0;
    redirect(br ? (tgt & 32'hFFFF_FFFC) : cur_pc + 32'd4);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    {mem[3], mem[2], mem[1], mem[0]}     = 32'h00208b33;
    {mem[7], mem[6], mem[5], mem[4]}     = 32'h40418bb3;
    {mem[27], mem[26], mem[25], mem[24]} = 32'h00e67e33;

    reset_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
    branch_valid = 1'b0; branch_target = 32'd0;
    repeat (2) tick();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addr", mem_addr, RESET_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr_ready   = $urandom_range(0, 1) == 1;
      branch_valid  = $urandom_range(0, 1) == 1;
      branch_target = $urandom_range(0, 31);
      tick();
      chk("idle_valid", {31'd0, instr_valid}, 32'd0);
      chk("idle_addr", mem_addr, RESET_PC);
    end
    instr_ready = 1'b0; branch_valid = 1'b0;

    // First word, long stall, then stream to the end of memory
    do_start();
    do_fetch(99, 32'd0);
    chk("first_word", instr, 32'h00208b33);
    do_hold(10, 1'b0, 32'd0);
    do_fetch(99, 32'd0);
    chk("second_word", instr, 32'h40418bb3);
    n = 2;
    while (!stopped && n < 20) begin
      do_hold(0, 1'b0, 32'd0);
      if (!stopped) begin
        do_fetch(99, 32'd0);
        n++;
      end
    end
    chk("instr_count", 32'(n), 32'd8);
    chk("end_done", {31'd0, done}, 32'd1);

    // Redirect mid-fetch, then out-of-range redirect from HOLD, then restart
    do_start();
    do_fetch(2, 32'h0000_0019);
    chk("branch_pc", cur_pc, 32'h18);
    do_fetch(99, 32'd0);
    chk("branch_word", instr, 32'h00e67e33);
    do_hold(2, 1'b1, 32'h40);
    chk("far_done", {31'd0, done}, 32'd1);
    do_start();
    do_fetch(99, 32'd0);
    chk("resume_pc", instr_pc, RESET_PC);

    // Asynchronous reset at FETCH cnt=3
    do_hold(0, 1'b0, 32'd0);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_addr", mem_addr, RESET_PC);
    chk("arst_instr", instr, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("post_rst_addr", mem_addr, RESET_PC);
    end

    // Randomized traffic against the model
    do_start();
    for (int it = 0; it < 60; it++) begin
      if (stopped)
        do_start();
      else if (in_hold)
        do_hold($urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 39));
      else
        do_fetch(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : 99,
                 $urandom_range(0, 39));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
